// File: rtl/imem_pkg.sv
// Shared types and helpers for the pipelined instruction memory.
//   fetch_rsp_t : one fetch response (instruction, PC, error flag)
//   addr_dec_t  : result of decoding a byte PC (word index, error flag)
//   decode_addr : strips the base offset and flags misaligned/out-of-range PCs
package imem_pkg;

    localparam logic [31:0] NOP_INST_DEF  = 32'h0000_0013;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } fetch_rsp_t;

    typedef struct packed {
        logic [29:0] idx;
        logic        err;
    } addr_dec_t;

    // span_bytes is 4*DEPTH, kept 33 bits wide so a 2^30-word memory still fits.
    // PCs below base wrap to a huge offset and fail the range test.
    function automatic addr_dec_t decode_addr(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span_bytes
    );
        logic [31:0] off;
        addr_dec_t   d;
        off   = addr - base;
        d.idx = off[31:2];
        d.err = (addr[1:0] != 2'b00) || ({1'b0, off} >= span_bytes);
        return d;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response FIFO that absorbs decode stalls behind the read register.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : drop all stored entries at the edge
//   push, push_data : enqueue one response
//   pop         : dequeue the head (only while cnt > 0)
//   head        : current head entry (valid while cnt > 0)
//   cnt         : number of stored entries, 0..2
module imem_rsp_fifo
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  fetch_rsp_t push_data,
    input  logic       pop,
    output fetch_rsp_t head,
    output logic [1:0] cnt
);

    fetch_rsp_t slots [2];
    logic       wr_ptr;
    logic       rd_ptr;

    assign head = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_data;
    end

    a_cnt_max: assert property (@(posedge clk) disable iff (rst) cnt <= 2'd2);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        !(push && !pop && cnt == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
        !(pop && cnt == 2'd0));

endmodule

// File: rtl/inst_mem_pipe.sv
// Synchronous-read instruction memory with a valid/ready fetch interface.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : fetch handshake, req_addr is the byte PC
//   flush                 : discard in-flight and queued responses
//   rsp_valid/rsp_ready   : response handshake with rsp_inst, rsp_pc, rsp_err
//   ld_we, ld_idx, ld_data: word write port for program loading
module inst_mem_pipe
  import imem_pkg::*;
#(
  parameter int unsigned  DEPTH     = 32768,
  parameter logic [31:0]  BASE_ADDR = BASE_ADDR_DEF,
  parameter               INIT_FILE = "",
  parameter logic [31:0]  NOP_INST  = NOP_INST_DEF,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_inst,
  output logic [31:0]      rsp_pc,
  output logic             rsp_err,
  input  logic             ld_we,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [31:0]      ld_data
);

  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) << 2;

  logic [31:0] mem [DEPTH];

  addr_dec_t        dec;
  logic [IDX_W-1:0] rd_idx;
  logic             unused_idx_hi;

  assign dec           = decode_addr(req_addr, BASE_ADDR, SPAN_BYTES);
  assign rd_idx        = dec.idx[IDX_W-1:0];
  assign unused_idx_hi = ^dec.idx[29:IDX_W];

  logic        pend;
  logic [31:0] rd_word;
  logic [31:0] rd_pc;
  logic        rd_err;
  fetch_rsp_t  rd_rsp;
  fetch_rsp_t  fifo_head;
  fetch_rsp_t  rsp_sel;
  logic [1:0]  cnt;
  logic        accept;
  logic        pop;
  logic        push;

  // Readiness depends only on registered occupancy, never on rsp_ready.
  assign req_ready = !rst && !flush && (({1'b0, cnt} + {2'b00, pend}) < 3'd2);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !rst && !flush && ((cnt != 2'd0) || pend);
  assign pop       = rsp_valid && rsp_ready;
  // The read register only bypasses the FIFO when it is the item being popped.
  assign push      = pend && !(pop && cnt == 2'd0) && !rst && !flush;

  // Read-first: a load to the fetched index in the same cycle returns the old word.
  always_ff @(posedge clk) begin
    if (ld_we)  mem[ld_idx] <= ld_data;
    if (accept) rd_word <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      pend <= accept;
    end
    if (accept) begin
      rd_pc  <= req_addr;
      rd_err <= dec.err;
    end
  end

  always_comb begin
    rd_rsp.inst = rd_err ? NOP_INST : rd_word;
    rd_rsp.pc   = rd_pc;
    rd_rsp.err  = rd_err;
    rsp_sel     = (cnt != 2'd0) ? fifo_head : rd_rsp;
  end

  assign rsp_inst = rsp_sel.inst;
  assign rsp_pc   = rsp_sel.pc;
  assign rsp_err  = rsp_sel.err;

  imem_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (rd_rsp),
    .pop       (pop && cnt != 2'd0),
    .head      (fifo_head),
    .cnt       (cnt)
  );

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Self-checking bench for inst_mem_pipe: a scoreboard of expected responses is
// filled on each accepted fetch and drained on each consumed response, plus
// direct cycle-level checks of handshake timing, flush, reset and errors.
module tb_inst_mem_pipe;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_addr = '0;
    logic             flush = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_inst;
    logic [31:0]      rsp_pc;
    logic             rsp_err;
    logic             ld_we = 1'b0;
    logic [IDX_W-1:0] ld_idx = '0;
    logic [31:0]      ld_data = '0;

    int total = 0;
    int bad   = 0;

    logic [31:0] shadow [DEPTH];
    logic [64:0] exp_q [$];

    inst_mem_pipe #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_pc    (rsp_pc),
        .rsp_err   (rsp_err),
        .ld_we     (ld_we),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference response for a PC, using the bench's own view of memory.
    function automatic logic [64:0] model(input logic [31:0] a);
        logic [63:0] top_ex;
        logic [31:0] widx;
        logic        e;
        top_ex = {32'b0, BASE} + 64'(DEPTH) * 64'd4;
        e = (a[1:0] != 2'b00) || (a < BASE) || ({32'b0, a} >= top_ex);
        widx = (a - BASE) >> 2;
        if (e) return {NOP, a, 1'b1};
        return {shadow[widx[IDX_W-1:0]], a, 1'b0};
    endfunction

    // Scoreboard monitor, sampled on the falling edge where inputs are stable.
    always @(negedge clk) begin
        if (rst || flush) begin
            check("valid_in_rst_flush", {95'b0, rsp_valid}, 96'd0);
            check("ready_in_rst_flush", {95'b0, req_ready}, 96'd0);
            exp_q.delete();
        end else begin
            if (exp_q.size() == 0) begin
                check("no_stale_rsp", {95'b0, rsp_valid}, 96'd0);
            end else begin
                check("rsp_valid_pending", {95'b0, rsp_valid}, 96'd1);
                if (rsp_valid && rsp_ready)
                    check("rsp_data", {31'b0, rsp_inst, rsp_pc, rsp_err}, {31'b0, exp_q.pop_front()});
            end
            if (req_valid && req_ready) exp_q.push_back(model(req_addr));
        end
        if (ld_we) shadow[ld_idx] = ld_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [IDX_W-1:0] idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_idx  = idx;
        ld_data = data;
        step();
        ld_we   = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("drain_empty", 96'(exp_q.size()), 96'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc;
        logic        was;

        // Reset state
        rst = 1'b1;
        repeat (2) step();
        check("rst_ready", {95'b0, req_ready}, 96'd0);
        check("rst_valid", {95'b0, rsp_valid}, 96'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {95'b0, req_ready}, 96'd1);

        // Program load
        for (int i = 0; i < 4; i++) load(IDX_W'(i), 32'h11 * (i + 1));
        load(IDX_W'(5), 32'h0000_AAAA);
        load(IDX_W'(DEPTH - 1), 32'hCAFE_0001);

        // Sequential PCs, one fetch per cycle, latency 1
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = BASE + 4 * i;
            check("seq_ready", {95'b0, req_ready}, 96'd1);
            step();
            check("seq_rsp", {30'b0, rsp_valid, rsp_inst, rsp_pc, rsp_err},
                  {30'b0, 1'b1, 32'h11 * (i + 1), BASE + 4 * i, 1'b0});
        end
        req_valid = 1'b0;
        step();
        check("seq_idle", {95'b0, rsp_valid}, 96'd0);

        // Backpressure: exactly two accepts, then stall
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = BASE;
        acc       = 0;
        for (int c = 0; c < 6; c++) begin
            was = req_ready;
            step();
            if (was) begin
                acc++;
                req_addr = req_addr + 32'd4;
            end
        end
        check("bp_accepts", 96'(acc), 96'd2);
        check("bp_ready", {95'b0, req_ready}, 96'd0);
        req_valid = 1'b0;
        drain();

        // Flush with two queued entries
        rsp_ready = 1'b0;
        fetch(BASE);
        fetch(BASE + 32'd4);
        step();
        check("fl_pre_valid", {95'b0, rsp_valid}, 96'd1);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = BASE + 32'd12;
        #1;
        check("fl_valid", {95'b0, rsp_valid}, 96'd0);
        check("fl_ready", {95'b0, req_ready}, 96'd0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("fl_after_valid", {95'b0, rsp_valid}, 96'd0);
        rsp_ready = 1'b1;
        fetch(BASE + 32'd8);
        check("fl_refetch", {63'b0, rsp_valid, rsp_inst}, {63'b0, 1'b1, 32'h33});
        drain();

        // Error responses and range boundaries
        fetch(BASE + 32'd2);
        check("err_misaligned", {62'b0, rsp_valid, rsp_err, rsp_inst}, {62'b0, 1'b1, 1'b1, NOP});
        fetch(BASE + 32'(4 * DEPTH));
        check("err_range", {94'b0, rsp_valid, rsp_err}, 96'b11);
        fetch(32'h7FFF_FFFC);
        check("err_below", {94'b0, rsp_valid, rsp_err}, 96'b11);
        fetch(BASE + 32'(4 * DEPTH - 4));
        check("last_word", {62'b0, rsp_valid, rsp_err, rsp_inst}, {62'b0, 1'b1, 1'b0, 32'hCAFE_0001});
        fetch(BASE);
        check("ok_base", {62'b0, rsp_valid, rsp_err, rsp_inst}, {62'b0, 1'b1, 1'b0, 32'h11});
        drain();

        // Load/fetch collision is read-first
        ld_we     = 1'b1;
        ld_idx    = IDX_W'(5);
        ld_data   = 32'h0000_BBBB;
        req_valid = 1'b1;
        req_addr  = BASE + 32'h14;
        step();
        ld_we     = 1'b0;
        req_valid = 1'b0;
        check("coll_old", {64'b0, rsp_inst}, {64'b0, 32'h0000_AAAA});
        fetch(BASE + 32'h14);
        check("coll_new", {64'b0, rsp_inst}, {64'b0, 32'h0000_BBBB});
        drain();

        // Reset mid-stream with pend=1, cnt=1
        rsp_ready = 1'b0;
        fetch(BASE);
        fetch(BASE + 32'd4);
        check("rst_mid_pre", {94'b0, rsp_valid, req_ready}, 96'b10);
        rst = 1'b1;
        step();
        check("rst_mid_valid", {95'b0, rsp_valid}, 96'd0);
        rst = 1'b0;
        #1;
        check("rst_mid_ready", {95'b0, req_ready}, 96'd1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_mid_nostale", {95'b0, rsp_valid}, 96'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
